// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath.
// Handshake: mem_ready is a completion strobe. FETCH, MEMRD and MEMWR keep their
// memory request asserted and hold state until a cycle with mem_ready=1 occurs.
// That cycle completes the access and the FSM advances on the next edge.
// Optional feature: define MC_ADDI_EN to add addi support (ADDIEX/ADDIWB states).
// Without it, opcode 001000 is treated as illegal.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_e state_q, state_d;
    // The opcode is only valid in DECODE, so lw/sw is remembered for MEMADR.
    logic   is_sw_q, is_sw_d;
    logic   illegal_dec;

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    // Next-state logic and opcode decode.
    always_comb begin
        state_d     = state_q;
        is_sw_d     = is_sw_q;
        illegal_dec = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d     = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode. While reset is low, all outputs are forced to zero.
    always_comb begin
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        iord        = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcsrc       = 2'b00;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        illegal     = 1'b0;
        state       = 4'd0;
        if (rst_n) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    illegal = illegal_dec;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop       = 2'b01;
                    pcwritecond = 1'b1;
                    pcsrc       = 2'b01;
                end
                S_JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end
`ifdef MC_ADDI_EN
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: random instruction stream checked against an
// instruction-level model (per-instruction state sequence plus per-state output table).
module tb_multicycle_control;

  localparam int W = 12;  // {state[3:0], mem_ready, opcode[5:0], illegal}

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5,
                         ST_EXEC = 4'd6, ST_ALUWB = 4'd7, ST_BRANCH = 4'd8,
                         ST_JUMP = 4'd9, ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic memread, memwrite, irwrite, iord, pcwrite, pcwritecond;
  logic [1:0] pcsrc;
  logic regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, aluop;
  logic [3:0] state;
  logic       illegal;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .iord(iord),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcsrc(pcsrc),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .state(state), .illegal(illegal)
  );

  logic [16:0] got_ctrl;
  assign got_ctrl = {memread, memwrite, irwrite, iord, pcwrite, pcwritecond, pcsrc,
                     regwrite, regdst, memtoreg, alusrca, alusrcb, aluop, illegal};

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) || (op == OP_J);
`ifdef MC_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

  // Output table per state, straight from the state descriptions.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic ill);
    logic rd, wr, irw, io, pcw, pcwc, rw, rdst, m2r, asa;
    logic [1:0] psrc, asb, aop;
    {rd, wr, irw, io, pcw, pcwc, rw, rdst, m2r, asa} = '0;
    psrc = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      ST_FETCH:  begin rd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE: asb = 2'b11;
      ST_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      ST_MEMRD:  begin rd = 1'b1; io = 1'b1; end
      ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      ST_MEMWR:  begin wr = 1'b1; io = 1'b1; end
      ST_EXEC:   begin asa = 1'b1; aop = 2'b10; end
      ST_ALUWB:  begin rw = 1'b1; rdst = 1'b1; end
      ST_BRANCH: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      ST_JUMP:   begin pcw = 1'b1; psrc = 2'b10; end
      ST_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      ST_ADDIWB: rw = 1'b1;
      default: ;
    endcase
    return {rd, wr, irw, io, pcw, pcwc, psrc, rw, rdst, m2r, asa, asb, aop, ill};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op, input logic ill);
    exp_q.push_back({st, mr, op, ill});
  endtask

  // One instruction: fw fetch wait cycles, mw data-memory wait cycles.
  task automatic build_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(ST_FETCH, 1'b0, rnd_op(), 1'b0);
    push(ST_FETCH, 1'b1, rnd_op(), 1'b0);
    push(ST_DECODE, rnd_bit(), op, !is_legal(op));
    if (op == OP_LW) begin
      push(ST_MEMADR, rnd_bit(), rnd_op(), 1'b0);
      for (int i = 0; i < mw; i++) push(ST_MEMRD, 1'b0, rnd_op(), 1'b0);
      push(ST_MEMRD, 1'b1, rnd_op(), 1'b0);
      push(ST_MEMWB, rnd_bit(), rnd_op(), 1'b0);
    end else if (op == OP_SW) begin
      push(ST_MEMADR, rnd_bit(), rnd_op(), 1'b0);
      for (int i = 0; i < mw; i++) push(ST_MEMWR, 1'b0, rnd_op(), 1'b0);
      push(ST_MEMWR, 1'b1, rnd_op(), 1'b0);
    end else if (op == OP_R) begin
      push(ST_EXEC, rnd_bit(), rnd_op(), 1'b0);
      push(ST_ALUWB, rnd_bit(), rnd_op(), 1'b0);
    end else if (op == OP_BEQ) begin
      push(ST_BRANCH, rnd_bit(), rnd_op(), 1'b0);
    end else if (op == OP_J) begin
      push(ST_JUMP, rnd_bit(), rnd_op(), 1'b0);
    end else if (is_legal(op)) begin
      push(ST_ADDIEX, rnd_bit(), rnd_op(), 1'b0);
      push(ST_ADDIWB, rnd_bit(), rnd_op(), 1'b0);
    end
  endtask

  // driver: called at posedge+1; drives inputs, checks at negedge, returns at next posedge+1
  task automatic run_entry();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    opcode = e[6:1];
    mem_ready = e[7];
    @(negedge clk);
    check($sformatf("state exp_st=%0d", e[11:8]), 32'(state), 32'(e[11:8]));
    check($sformatf("ctrl st=%0d mr=%0d", e[11:8], e[7]), 32'(got_ctrl),
          32'(exp_ctrl(e[11:8], e[7], e[0])));
    @(posedge clk);
    #1;
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) run_entry();
  endtask

  initial begin
    // reset with active inputs: everything must be zero
    rst_n = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(got_ctrl), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_memread", 32'(memread), 32'd1);
    check("rel_state", 32'(state), 32'd0);

    // directed instructions
    build_instr(OP_R, 0, 0);
    build_instr(OP_LW, 0, 3);
    build_instr(OP_BEQ, 0, 0);
    build_instr(6'b111111, 0, 0);
    build_instr(OP_ADDI, 0, 0);
    build_instr(OP_J, 1, 0);
    build_instr(OP_SW, 2, 1);
    build_instr(OP_LW, 0, 0);
    build_instr(OP_SW, 0, 0);
    run_all();

    // random instruction mix
    for (int n = 0; n < 120; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        default: op = rnd_op();
      endcase
      build_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run_all();
    end

    // reset asserted during a MEMWR wait
    build_instr(OP_SW, 0, 4);
    repeat (4) run_entry();  // FETCH, DECODE, MEMADR, first MEMWR wait
    opcode = rnd_op();
    mem_ready = 1'b0;
    #2;
    check("sw_wait_state", 32'(state), 32'(ST_MEMWR));
    check("sw_wait_memwrite", 32'(memwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_memwrite", 32'(memwrite), 32'd0);
    check("midrst_ctrl", 32'(got_ctrl), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    build_instr(OP_LW, 0, 1);
    build_instr(OP_R, 0, 0);
    run_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
